// File: rtl/dbus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder_if
// Brief    : Core data-port and console/interrupt bundle for dbus_responder.
// Revision : 1.0
// ============================================================================
interface dbus_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] writedata;
  logic             memwrite;
  logic [WIDTH-1:0] readdata;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             irq;

  modport master (
    output addr, writedata, memwrite, tx_ready,
    input  readdata, tx_valid, tx_data, irq
  );

  modport slave (
    input  addr, writedata, memwrite, tx_ready,
    output readdata, tx_valid, tx_data, irq
  );
endinterface
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder
// Brief    : Data-port slave decoding word RAM, a console TX FIFO and a timer.
// Revision : 1.0
// ============================================================================
module dbus_responder #(
  parameter int WIDTH     = 32,
  parameter int DMEMDEPTH = 14,
  parameter int FIFODEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  dbus_responder_if.slave bus
);
  localparam int c_PTR_W     = $clog2(FIFODEPTH);
  localparam int c_CNT_W     = c_PTR_W + 1;
  localparam int c_RAM_WORDS = 1 << DMEMDEPTH;

  logic [WIDTH-1:0]     r_ram [c_RAM_WORDS];
  logic [7:0]           r_fifo [FIFODEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic [WIDTH-1:0]     r_counter;
  logic                 r_enable;
  logic                 r_expired;

  logic                 w_ram_sel;
  logic                 w_mmio_sel;
  logic [1:0]           w_off;
  logic [DMEMDEPTH-1:0] w_ram_idx;
  logic                 w_wr_txdata;
  logic                 w_wr_tload;
  logic                 w_wr_tctrl;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic                 w_dec;
  logic                 w_fire;
  logic [WIDTH-1:0]     w_rdata;
  logic                 w_unused_addr;

  assign w_ram_sel   = (bus.addr[WIDTH-1:16] == '0);
  assign w_mmio_sel  = (bus.addr[WIDTH-1:4] == '1);
  assign w_off       = bus.addr[3:2];
  assign w_ram_idx   = bus.addr[DMEMDEPTH+1:2];
  assign w_wr_txdata = bus.memwrite & w_mmio_sel & (w_off == 2'd0);
  assign w_wr_tload  = bus.memwrite & w_mmio_sel & (w_off == 2'd2);
  assign w_wr_tctrl  = bus.memwrite & w_mmio_sel & (w_off == 2'd3);
  assign w_unused_addr = ^{bus.addr[1:0], bus.addr[15:2]};

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_CNT_W'(FIFODEPTH));
  assign w_pop     = !w_empty & bus.tx_ready;
  assign w_push_ok = w_wr_txdata & (!w_full | w_pop);
  assign w_drop    = w_wr_txdata & w_full & !w_pop;

  assign w_dec  = r_enable & (r_counter != '0) & !w_wr_tload;
  assign w_fire = w_dec & (r_counter == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (bus.memwrite && w_ram_sel) begin
      r_ram[w_ram_idx] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus.writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - c_CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Load wins over decrement; a same-cycle expiry wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_counter <= '0;
      r_enable  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      if (w_wr_tload)  r_counter <= bus.writedata;
      else if (w_dec)  r_counter <= r_counter - WIDTH'(1);
      if (w_wr_tctrl)  r_enable  <= bus.writedata[0];
      if (w_fire)      r_expired <= 1'b1;
      else if (w_wr_tctrl && bus.writedata[1]) r_expired <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_sel) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_mmio_sel) begin
      case (w_off)
        2'd1:    w_rdata = {{(WIDTH-8){1'b0}}, 4'(r_count), 1'b0, r_overflow, w_full, w_empty};
        2'd2:    w_rdata = r_counter;
        2'd3:    w_rdata = {{(WIDTH-2){1'b0}}, r_expired, r_enable};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.readdata = w_rdata;
  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign bus.irq      = r_expired;
endmodule
`default_nettype wire
